// File: rtl/asic_cmd_unit.sv
// RoCC command front-end for the systolic array: config decode, launch, cycle count, response.
// Optional ASIC_CMD_ERRCHK_EN: illegal funct/dimension checking with sticky err flag.
`ifndef XLEN
`define XLEN 64
`endif

module asic_cmd_unit #(
  parameter int unsigned MAX_DIM = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic              cmd_ready_o,
  input  logic              cmd_valid_i,
  input  logic [6:0]        cmd_inst_funct_i,
  input  logic [4:0]        cmd_inst_rs2_i,
  input  logic [4:0]        cmd_inst_rs1_i,
  input  logic              cmd_inst_xd_i,
  input  logic              cmd_inst_xs1_i,
  input  logic              cmd_inst_xs2_i,
  input  logic [4:0]        cmd_inst_rd_i,
  input  logic [6:0]        cmd_inst_opcode_i,
  input  logic [`XLEN-1:0]  cmd_rs1_i,
  input  logic              resp_ready_i,
  output logic              resp_valid_o,
  output logic [4:0]        resp_rd_o,
  output logic [`XLEN-1:0]  resp_data_o,
  output logic [39:0]       cfg_a_addr_o,
  output logic [39:0]       cfg_b_addr_o,
  output logic [39:0]       cfg_c_addr_o,
  output logic [7:0]        cfg_m_o,
  output logic [7:0]        cfg_n_o,
  output logic [7:0]        cfg_k_o,
  output logic              start_o,
  input  logic              busy_i,
  input  logic              done_i
);

`ifdef ASIC_CMD_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  localparam logic [6:0] F_SET_A  = 7'd0;
  localparam logic [6:0] F_SET_B  = 7'd1;
  localparam logic [6:0] F_SET_C  = 7'd2;
  localparam logic [6:0] F_SET_D  = 7'd3;
  localparam logic [6:0] F_START  = 7'd4;
  localparam logic [6:0] F_STATUS = 7'd5;
  localparam logic [7:0] MAX_DIM_B = 8'(MAX_DIM);

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_RESP} state_e;

  state_e             state_q, state_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               start_q, start_d;
  logic               resp_valid_q, resp_valid_d;
  logic [4:0]         resp_rd_q, resp_rd_d;
  logic [`XLEN-1:0]   resp_data_q, resp_data_d;
  logic [39:0]        cfg_a_q, cfg_a_d, cfg_b_q, cfg_b_d, cfg_c_q, cfg_c_d;
  logic [7:0]         cfg_m_q, cfg_m_d, cfg_n_q, cfg_n_d, cfg_k_q, cfg_k_d;
  logic [31:0]        counter_q, counter_d, last_count_q, last_count_d;
  logic               err_q, err_d;
  logic               xd_pend_q, xd_pend_d;
  logic [31:0]        count_inc;
  logic               dims_bad;
  logic               launch_ok;

  logic unused_ok;
  assign unused_ok = ^{cmd_inst_rs2_i, cmd_inst_rs1_i, cmd_inst_xs1_i, cmd_inst_xs2_i,
                       cmd_inst_opcode_i, cmd_rs1_i[`XLEN-1:40]};

  assign count_inc = (counter_q == 32'hFFFF_FFFF) ? counter_q : counter_q + 32'd1;
  assign dims_bad  = (cfg_m_q == 8'd0) || (cfg_n_q == 8'd0) || (cfg_k_q == 8'd0) ||
                     (cfg_m_q > MAX_DIM_B) || (cfg_n_q > MAX_DIM_B) || (cfg_k_q > MAX_DIM_B);
  assign launch_ok = !(ERRCHK && dims_bad);

  always_comb begin
    state_d      = state_q;
    resp_rd_d    = resp_rd_q;
    resp_data_d  = resp_data_q;
    cfg_a_d      = cfg_a_q;
    cfg_b_d      = cfg_b_q;
    cfg_c_d      = cfg_c_q;
    cfg_m_d      = cfg_m_q;
    cfg_n_d      = cfg_n_q;
    cfg_k_d      = cfg_k_q;
    counter_d    = counter_q;
    last_count_d = last_count_q;
    err_d        = err_q;
    xd_pend_d    = xd_pend_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          resp_rd_d   = cmd_inst_rd_i;
          resp_data_d = '0;
          case (cmd_inst_funct_i)
            F_SET_A: cfg_a_d = cmd_rs1_i[39:0];
            F_SET_B: cfg_b_d = cmd_rs1_i[39:0];
            F_SET_C: cfg_c_d = cmd_rs1_i[39:0];
            F_SET_D: begin
              cfg_m_d = cmd_rs1_i[7:0];
              cfg_n_d = cmd_rs1_i[15:8];
              cfg_k_d = cmd_rs1_i[23:16];
            end
            F_STATUS: begin
              resp_data_d[63:0] = {last_count_q, 30'd0, busy_i, err_q};
              if (ERRCHK) err_d = 1'b0;
            end
            F_START: begin
              if (!launch_ok) begin
                err_d       = 1'b1;
                resp_data_d = '1;
              end
            end
            default: begin
              if (ERRCHK) begin
                err_d       = 1'b1;
                resp_data_d = '1;
              end
            end
          endcase
          if (cmd_inst_funct_i == F_START && launch_ok) begin
            state_d   = S_START;
            xd_pend_d = cmd_inst_xd_i;
          end else if (cmd_inst_xd_i) begin
            state_d = S_RESP;
          end
        end
      end
      S_START: begin
        counter_d = 32'd0;
        state_d   = S_RUN;
      end
      S_RUN: begin
        // The done cycle itself is counted, so a done in the first RUN cycle reports 1.
        counter_d = count_inc;
        if (done_i) begin
          last_count_d = count_inc;
          resp_data_d  = {{(`XLEN-32){1'b0}}, count_inc};
          state_d      = xd_pend_q ? S_RESP : S_IDLE;
        end
      end
      S_RESP: begin
        if (resp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    cmd_ready_d  = (state_d == S_IDLE);
    start_d      = (state_d == S_START);
    resp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cmd_ready_q  <= 1'b1;
      start_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rd_q    <= '0;
      resp_data_q  <= '0;
      cfg_a_q      <= '0;
      cfg_b_q      <= '0;
      cfg_c_q      <= '0;
      cfg_m_q      <= '0;
      cfg_n_q      <= '0;
      cfg_k_q      <= '0;
      counter_q    <= '0;
      last_count_q <= '0;
      err_q        <= 1'b0;
      xd_pend_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      start_q      <= start_d;
      resp_valid_q <= resp_valid_d;
      resp_rd_q    <= resp_rd_d;
      resp_data_q  <= resp_data_d;
      cfg_a_q      <= cfg_a_d;
      cfg_b_q      <= cfg_b_d;
      cfg_c_q      <= cfg_c_d;
      cfg_m_q      <= cfg_m_d;
      cfg_n_q      <= cfg_n_d;
      cfg_k_q      <= cfg_k_d;
      counter_q    <= counter_d;
      last_count_q <= last_count_d;
      err_q        <= err_d;
      xd_pend_q    <= xd_pend_d;
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign start_o      = start_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rd_o    = resp_rd_q;
  assign resp_data_o  = resp_data_q;
  assign cfg_a_addr_o = cfg_a_q;
  assign cfg_b_addr_o = cfg_b_q;
  assign cfg_c_addr_o = cfg_c_q;
  assign cfg_m_o      = cfg_m_q;
  assign cfg_n_o      = cfg_n_q;
  assign cfg_k_o      = cfg_k_q;

endmodule

// File: tb/tb_asic_cmd_unit.sv
// Scoreboard bench for asic_cmd_unit: directed commands, expected responses queued and checked by a monitor.
`ifndef XLEN
`define XLEN 64
`endif

module tb_asic_cmd_unit;
  localparam int XL = `XLEN;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_ready_o, cmd_valid_i;
  logic [6:0]    cmd_inst_funct_i, cmd_inst_opcode_i;
  logic [4:0]    cmd_inst_rs2_i, cmd_inst_rs1_i, cmd_inst_rd_i;
  logic          cmd_inst_xd_i, cmd_inst_xs1_i, cmd_inst_xs2_i;
  logic [XL-1:0] cmd_rs1_i;
  logic          resp_ready_i, resp_valid_o;
  logic [4:0]    resp_rd_o;
  logic [XL-1:0] resp_data_o;
  logic [39:0]   cfg_a_addr_o, cfg_b_addr_o, cfg_c_addr_o;
  logic [7:0]    cfg_m_o, cfg_n_o, cfg_k_o;
  logic          start_o, busy_i, done_i;

  asic_cmd_unit #(.MAX_DIM(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_ready_o(cmd_ready_o), .cmd_valid_i(cmd_valid_i),
    .cmd_inst_funct_i(cmd_inst_funct_i), .cmd_inst_rs2_i(cmd_inst_rs2_i),
    .cmd_inst_rs1_i(cmd_inst_rs1_i), .cmd_inst_xd_i(cmd_inst_xd_i),
    .cmd_inst_xs1_i(cmd_inst_xs1_i), .cmd_inst_xs2_i(cmd_inst_xs2_i),
    .cmd_inst_rd_i(cmd_inst_rd_i), .cmd_inst_opcode_i(cmd_inst_opcode_i),
    .cmd_rs1_i(cmd_rs1_i), .resp_ready_i(resp_ready_i),
    .resp_valid_o(resp_valid_o), .resp_rd_o(resp_rd_o), .resp_data_o(resp_data_o),
    .cfg_a_addr_o(cfg_a_addr_o), .cfg_b_addr_o(cfg_b_addr_o), .cfg_c_addr_o(cfg_c_addr_o),
    .cfg_m_o(cfg_m_o), .cfg_n_o(cfg_n_o), .cfg_k_o(cfg_k_o),
    .start_o(start_o), .busy_i(busy_i), .done_i(done_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]    rd;
    logic [XL-1:0] data;
  } resp_t;

  resp_t         exp_q[$];
  resp_t         e_m;
  int            tests = 0;
  int            fails = 0;
  int            start_cnt = 0;
  logic          pv = 1'b0, pr = 1'b0;
  logic [4:0]    prd = '0;
  logic [XL-1:0] pdat = '0;
  logic [XL-1:0] ones = '1;

  task automatic check(input string name, input logic [XL-1:0] act, input logic [XL-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [XL-1:0] stat(input logic [31:0] cnt, input logic b, input logic e);
    logic [XL-1:0] r = '0;
    r[63:0] = {cnt, 30'd0, b, e};
    return r;
  endfunction

  task automatic push(input logic [4:0] rd, input logic [XL-1:0] data);
    exp_q.push_back({rd, data});
  endtask

  // Monitor: scoreboard pop on handshake, plus hold-stability while stalled.
  always @(negedge clk) begin
    if (start_o) start_cnt++;
    if (reset && pv && !pr) begin
      check("resp_hold_valid", XL'(resp_valid_o), XL'(1));
      check("resp_hold_rd", XL'(resp_rd_o), XL'(prd));
      check("resp_hold_data", resp_data_o, pdat);
    end
    if (resp_valid_o && resp_ready_i) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: got rd=%0d data=0x%0h, expected no response", resp_rd_o, resp_data_o);
      end else begin
        e_m = exp_q.pop_front();
        check("resp_rd", XL'(resp_rd_o), XL'(e_m.rd));
        check("resp_data", resp_data_o, e_m.data);
      end
    end
    pv   <= resp_valid_o && reset;
    pr   <= resp_ready_i;
    prd  <= resp_rd_o;
    pdat <= resp_data_o;
  end

  task automatic send_cmd(input logic [6:0] f, input logic xd, input logic [4:0] rd, input logic [XL-1:0] rs1);
    int n = 0;
    cmd_valid_i       = 1'b1;
    cmd_inst_funct_i  = f;
    cmd_inst_xd_i     = xd;
    cmd_inst_rd_i     = rd;
    cmd_rs1_i         = rs1;
    cmd_inst_rs2_i    = 5'($urandom);
    cmd_inst_rs1_i    = 5'($urandom);
    cmd_inst_opcode_i = 7'($urandom);
    @(negedge clk);
    while (!cmd_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready_o) begin
      tests++;
      fails++;
      $display("FAIL cmd_accept_timeout: got cmd_ready_o=0 after %0d cycles, expected 1", n);
    end
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("resp_drain_pending", XL'(exp_q.size()), XL'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int low_cnt;
    reset = 1'b0; cmd_valid_i = 1'b0; cmd_inst_funct_i = '0; cmd_inst_opcode_i = '0;
    cmd_inst_rs2_i = '0; cmd_inst_rs1_i = '0; cmd_inst_rd_i = '0; cmd_inst_xd_i = 1'b0;
    cmd_inst_xs1_i = 1'b1; cmd_inst_xs2_i = 1'b1; cmd_rs1_i = '0;
    resp_ready_i = 1'b1; busy_i = 1'b0; done_i = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_cmd_ready", XL'(cmd_ready_o), XL'(1));
    check("rst_resp_valid", XL'(resp_valid_o), XL'(0));
    check("rst_resp_rd", XL'(resp_rd_o), XL'(0));
    check("rst_resp_data", resp_data_o, XL'(0));
    check("rst_start", XL'(start_o), XL'(0));
    check("rst_cfg_a", XL'(cfg_a_addr_o), XL'(0));
    check("rst_cfg_mnk", XL'({cfg_m_o, cfg_n_o, cfg_k_o}), XL'(0));
    @(posedge clk); #1 reset = 1'b1;

    // SET_A / SET_DIM without response
    send_cmd(7'd0, 1'b0, 5'd1, XL'(40'h12_3456_7890));
    send_cmd(7'd3, 1'b0, 5'd1, XL'(24'h040302));
    @(negedge clk);
    check("cfg_a", XL'(cfg_a_addr_o), XL'(40'h12_3456_7890));
    check("cfg_m", XL'(cfg_m_o), XL'(2));
    check("cfg_n", XL'(cfg_n_o), XL'(3));
    check("cfg_k", XL'(cfg_k_o), XL'(4));
    check("set_no_resp", XL'(resp_valid_o), XL'(0));
    check("set_cmd_ready", XL'(cmd_ready_o), XL'(1));
    @(posedge clk); #1;

    // SET_B with response held under backpressure
    resp_ready_i = 1'b0;
    push(5'd7, XL'(0));
    send_cmd(7'd1, 1'b1, 5'd7, XL'(40'hAB));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", XL'(resp_valid_o), XL'(1));
      check("bp_rd", XL'(resp_rd_o), XL'(7));
      check("bp_cmd_ready", XL'(cmd_ready_o), XL'(0));
    end
    @(posedge clk); #1 resp_ready_i = 1'b1;
    drain();
    @(negedge clk);
    check("post_resp_ready", XL'(cmd_ready_o), XL'(1));
    check("post_resp_valid", XL'(resp_valid_o), XL'(0));
    check("cfg_b", XL'(cfg_b_addr_o), XL'(40'hAB));
    @(posedge clk); #1;

    // START xd=1, done 10 cycles after start_o; done during start_o cycle ignored
    s0 = start_cnt;
    low_cnt = 0;
    push(5'd5, XL'(10));
    send_cmd(7'd4, 1'b1, 5'd5, XL'(0));
    for (int i = 0; i < 10; i++) begin
      if (i == 0) done_i = 1'b1;
      @(negedge clk);
      if (!cmd_ready_o) low_cnt++;
      if (i == 0) check("start_pulse_first", XL'(start_o), XL'(1));
      @(posedge clk); #1 done_i = 1'b0;
    end
    done_i = 1'b1;
    @(negedge clk);
    if (!cmd_ready_o) low_cnt++;
    @(posedge clk); #1 done_i = 1'b0;
    check("start_single_pulse", XL'(start_cnt - s0), XL'(1));
    check("run_cmd_ready_low", XL'(low_cnt), XL'(11));
    drain();

    // START xd=0 then GET_STATUS stalls until done
    s0 = start_cnt;
    busy_i = 1'b1;
    send_cmd(7'd4, 1'b0, 5'd0, XL'(0));
    push(5'd2, stat(32'd5, 1'b1, 1'b0));
    fork
      begin
        repeat (5) @(posedge clk);
        #1 done_i = 1'b1;
        @(posedge clk);
        #1 done_i = 1'b0;
      end
      begin
        @(negedge clk);
        check("run_stall_ready", XL'(cmd_ready_o), XL'(0));
      end
      send_cmd(7'd5, 1'b1, 5'd2, XL'(0));
    join
    drain();
    busy_i = 1'b0;
    check("start_xd0_pulse", XL'(start_cnt - s0), XL'(1));

    // done in first RUN cycle -> count 1
    push(5'd6, XL'(1));
    send_cmd(7'd4, 1'b1, 5'd6, XL'(0));
    @(posedge clk); #1 done_i = 1'b1;
    @(posedge clk); #1 done_i = 1'b0;
    drain();

`ifdef ASIC_CMD_ERRCHK_EN
    send_cmd(7'd3, 1'b0, 5'd0, XL'(24'h000302));
    s0 = start_cnt;
    push(5'd3, ones);
    send_cmd(7'd4, 1'b1, 5'd3, XL'(0));
    drain();
    check("err_no_launch", XL'(start_cnt - s0), XL'(0));
    push(5'd4, stat(32'd1, 1'b0, 1'b1));
    send_cmd(7'd5, 1'b1, 5'd4, XL'(0));
    drain();
    push(5'd4, stat(32'd1, 1'b0, 1'b0));
    send_cmd(7'd5, 1'b1, 5'd4, XL'(0));
    drain();
    push(5'd9, ones);
    send_cmd(7'd9, 1'b1, 5'd9, XL'(0));
    drain();
    send_cmd(7'd5, 1'b0, 5'd0, XL'(0));
    push(5'd4, stat(32'd1, 1'b0, 1'b0));
    send_cmd(7'd5, 1'b1, 5'd4, XL'(0));
    drain();
    send_cmd(7'd3, 1'b0, 5'd0, XL'(24'h110101));
    s0 = start_cnt;
    push(5'd3, ones);
    send_cmd(7'd4, 1'b1, 5'd3, XL'(0));
    drain();
    check("err_maxdim_no_launch", XL'(start_cnt - s0), XL'(0));
    push(5'd4, stat(32'd1, 1'b0, 1'b1));
    send_cmd(7'd5, 1'b1, 5'd4, XL'(0));
    drain();
`else
    push(5'd9, XL'(0));
    send_cmd(7'd9, 1'b1, 5'd9, XL'(0));
    drain();
    send_cmd(7'd3, 1'b0, 5'd0, XL'(24'h000302));
    s0 = start_cnt;
    push(5'd3, XL'(1));
    send_cmd(7'd4, 1'b1, 5'd3, XL'(0));
    @(posedge clk); #1 done_i = 1'b1;
    @(posedge clk); #1 done_i = 1'b0;
    drain();
    check("nochk_launch", XL'(start_cnt - s0), XL'(1));
    push(5'd4, stat(32'd1, 1'b0, 1'b0));
    send_cmd(7'd5, 1'b1, 5'd4, XL'(0));
    drain();
`endif

    // Reset during RUN
    send_cmd(7'd3, 1'b0, 5'd0, XL'(24'h040302));
    s0 = start_cnt;
    send_cmd(7'd4, 1'b0, 5'd0, XL'(0));
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rrun_launched", XL'(start_cnt - s0), XL'(1));
    check("rrun_start", XL'(start_o), XL'(0));
    check("rrun_resp_valid", XL'(resp_valid_o), XL'(0));
    check("rrun_cfg_a", XL'(cfg_a_addr_o), XL'(0));
    check("rrun_cfg_b", XL'(cfg_b_addr_o), XL'(0));
    check("rrun_cfg_mnk", XL'({cfg_m_o, cfg_n_o, cfg_k_o}), XL'(0));
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("rrun_cmd_ready", XL'(cmd_ready_o), XL'(1));
    @(posedge clk); #1;
    push(5'd1, stat(32'd0, 1'b0, 1'b0));
    send_cmd(7'd5, 1'b1, 5'd1, XL'(0));
    drain();

    check("final_queue_empty", XL'(exp_q.size()), XL'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
